// File: rtl/mult_seq_16b_if.sv
// Operand/result bundle for mult_seq_16b: start/busy/done handshake plus operands and product.
// The master is the pipeline control that requests a multiply; the slave is the multiplier.
interface mult_seq_16b_if #(
  parameter int N = 16
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic           err;

  modport master (
    output start, a, b,
    input  busy, done, product, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, err
  );
endinterface

// File: rtl/mult_seq_16b.sv
// Sequential unsigned 16x16 shift-add multiplier through a 16-bit CLA: 17 cycles start-to-done.
// No backpressure; start during RUN is dropped and flagged on err, start during done chains a new run.
module cla_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out,
  output logic        err
);
  logic [15:0] w_p, w_g;
  logic [16:0] w_c;
  logic [3:0]  w_gg, w_gp;
  logic [4:0]  w_gc;
  logic [16:0] w_ref;

  assign w_p = A ^ B;
  assign w_g = A & B;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_gc = '0;
    w_c  = '0;
    w_gc[0] = C_in;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
    w_c[16] = w_gc[4];
  end

  assign S     = w_p ^ w_c[15:0];
  assign C_out = w_c[16];
  // Redundant behavioural sum guards the lookahead network.
  assign w_ref = {1'b0, A} + {1'b0, B} + {16'b0, C_in};
  assign err   = ({C_out, S} != w_ref);
endmodule

module mult_seq_16b #(
  parameter int N = 16
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_16b_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_acc_hi;
  logic [N-1:0]   r_acc_lo;
  logic [4:0]     r_cnt;
  logic [2*N-1:0] r_product;
  logic           r_err;

  logic [N-1:0]   w_add_b;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_add_err;
  logic [2*N-1:0] w_next_acc;

  assign w_add_b    = r_acc_lo[0] ? r_mcand : '0;
  assign w_next_acc = {w_cout, w_sum, r_acc_lo[N-1:1]};

  cla_16b u_cla (
    .A     (r_acc_hi),
    .B     (w_add_b),
    .C_in  (1'b0),
    .S     (w_sum),
    .C_out (w_cout),
    .err   (w_add_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        RUN: begin
          {r_acc_hi, r_acc_lo} <= w_next_acc;
          r_cnt <= r_cnt + 5'd1;
          if (bus.start || w_add_err) r_err <= 1'b1;
          if (r_cnt == 5'd15) begin
            r_product <= w_next_acc;
            r_state   <= DONE;
          end
        end
        default: begin
          // IDLE and DONE accept a request identically, giving gapless back-to-back runs.
          if (bus.start) begin
            r_mcand  <= bus.a;
            r_acc_lo <= bus.b;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy    = (r_state == RUN);
  assign bus.done    = (r_state == DONE);
  assign bus.product = r_product;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_mult_seq_16b.sv
// Directed bench for mult_seq_16b: latency, busy width, products, protocol err, chaining, async reset.
module tb_mult_seq_16b;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   g_edges, g_busy, g_err, n_done;

  mult_seq_16b_if #(.N(16)) bus ();

  mult_seq_16b #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until done is seen or the edge budget is used, tallying busy and err samples.
  task automatic wait_done(input int lim);
    while (bus.done !== 1'b1 && g_edges < lim) begin
      if (bus.busy === 1'b1) g_busy++;
      if (bus.err === 1'b1) g_err++;
      step();
      g_edges++;
    end
  endtask

  task automatic clear_tally();
    g_edges = 0;
    g_busy  = 0;
    g_err   = 0;
  endtask

  task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    clear_tally();
    wait_done(40);
    check({tag, "_latency"}, g_edges, 16);
    check({tag, "_busy_cycles"}, g_busy, 16);
    check({tag, "_err"}, g_err, 0);
    check({tag, "_product"}, bus.product, exp);
    step();
    check({tag, "_done_single"}, bus.done, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_product", bus.product, 32'h0);
    rst = 1'b0;

    run_mult(16'd3, 16'd5, 32'h0000000F, "m3x5");
    run_mult(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mffff");
    run_mult(16'h0000, 16'h1234, 32'h0, "mzero_a");
    run_mult(16'h1234, 16'h0000, 32'h0, "mzero_b");

    // Stray start mid-run must be rejected without disturbing the result.
    bus.a = 16'h00FF;
    bus.b = 16'h0101;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    clear_tally();
    wait_done(4);
    bus.a = 16'd7;
    bus.b = 16'd7;
    bus.start = 1'b1;
    wait_done(5);
    bus.start = 1'b0;
    wait_done(40);
    check("viol_latency", g_edges, 16);
    check("viol_err_pulses", g_err, 1);
    check("viol_product", bus.product, 32'h0000FFFF);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done === 1'b1) n_done++;
    end
    check("viol_no_second_done", n_done, 0);

    // Back-to-back: second request presented during the done cycle.
    bus.a = 16'h0011;
    bus.b = 16'h0003;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    clear_tally();
    wait_done(40);
    check("b2b_first_latency", g_edges, 16);
    check("b2b_first_product", bus.product, 32'h00000033);
    bus.a = 16'h8000;
    bus.b = 16'h0002;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("b2b_second_busy", bus.busy, 1'b1);
    check("b2b_product_held", bus.product, 32'h00000033);
    clear_tally();
    wait_done(40);
    check("b2b_second_latency", g_edges, 16);
    check("b2b_second_product", bus.product, 32'h00010000);
    step();

    // Asynchronous reset in the middle of cycle 8 of a run.
    bus.a = 16'h1234;
    bus.b = 16'h0010;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    clear_tally();
    wait_done(7);
    check("arst_pre_busy", bus.busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_product", bus.product, 32'h0);
    #1;
    rst = 1'b0;
    bus.a = 16'd9;
    bus.b = 16'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("arst_restart_busy", bus.busy, 1'b1);
    clear_tally();
    wait_done(40);
    check("arst_restart_latency", g_edges, 16);
    check("arst_restart_product", bus.product, 32'd81);
    check("arst_restart_err", g_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
